// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: two-requester register-file move/load-immediate sequencer, rev 1.0
// Load-immediate support is compiled in only when REG_SEQ_IMMEDIATE_EN is defined.
`default_nettype none

module reg_bus_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              seq_clock,
  input  logic              seq_reset_n,
  input  logic              req_a_valid,
  input  logic [1:0]        req_a_src,
  input  logic [1:0]        req_a_dst,
  input  logic              req_a_imm_sel,
  input  logic [DATA_W-1:0] req_a_imm,
  input  logic              req_b_valid,
  input  logic [1:0]        req_b_src,
  input  logic [1:0]        req_b_dst,
  input  logic              req_b_imm_sel,
  input  logic [DATA_W-1:0] req_b_imm,
  output logic              done_a,
  output logic              done_b,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_in_en,
  output logic              reg_out_en,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ptr;        // 0 = A has priority, 1 = B has priority
  logic              owner;      // 0 = A granted, 1 = B granted
  logic [1:0]        src_q;
  logic [1:0]        dst_q;
  logic              imm_sel_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] temp;

  logic              any_valid;
  logic              grant_b;
  logic [1:0]        sel_src;
  logic [1:0]        sel_dst;
  logic              sel_imm_sel;
  logic [DATA_W-1:0] sel_imm;

  assign any_valid = req_a_valid | req_b_valid;
  assign grant_b   = req_b_valid & (~req_a_valid | ptr);
  assign sel_src   = grant_b ? req_b_src : req_a_src;
  assign sel_dst   = grant_b ? req_b_dst : req_a_dst;

`ifdef REG_SEQ_IMMEDIATE_EN
  assign sel_imm_sel = grant_b ? req_b_imm_sel : req_a_imm_sel;
  assign sel_imm     = grant_b ? req_b_imm : req_a_imm;
`else
  assign sel_imm_sel = 1'b0;
  assign sel_imm     = '0;
  logic unused_imm;
  assign unused_imm = ^{req_a_imm_sel, req_b_imm_sel, req_a_imm, req_b_imm};
`endif

  always_ff @(posedge seq_clock or negedge seq_reset_n) begin
    if (!seq_reset_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      src_q     <= 2'd0;
      dst_q     <= 2'd0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      temp      <= '0;
    end else begin
      state <= state_nxt;
      // Request fields are captured only at grant; later changes are ignored.
      if (state == IDLE && any_valid) begin
        owner     <= grant_b;
        ptr       <= ~grant_b;
        src_q     <= sel_src;
        dst_q     <= sel_dst;
        imm_sel_q <= sel_imm_sel;
        imm_q     <= sel_imm;
      end
      if (state == READ) begin
        temp <= reg_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    reg_addr   = '0;
    reg_in_en  = 1'b0;
    reg_out_en = 1'b0;
    reg_wdata  = '0;
    done_a     = 1'b0;
    done_b     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = sel_imm_sel ? WRITE : READ;
        end
      end
      READ: begin
        reg_addr   = ADDR_W'(src_q);
        reg_out_en = 1'b1;
        state_nxt  = WRITE;
      end
      WRITE: begin
        reg_addr  = ADDR_W'(dst_q);
        reg_in_en = 1'b1;
        reg_wdata = imm_sel_q ? imm_q : temp;
        state_nxt = ACK;
      end
      ACK: begin
        done_a    = ~owner;
        done_b    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer: directed table-driven bench for reg_bus_sequencer.
`default_nettype none

module tb_reg_bus_sequencer;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, a_imm_sel, b_imm_sel;
  logic [1:0]    a_src, a_dst, b_src, b_dst;
  logic [DW-1:0] a_imm, b_imm;
  logic          done_a, done_b, reg_in_en, reg_out_en, busy;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata, bus_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bus model: the register file only drives valid data while enabled.
  assign reg_rdata = reg_out_en ? bus_val : 16'hDEAD;

  reg_bus_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .seq_clock(clk), .seq_reset_n(rst_n),
    .req_a_valid(a_valid), .req_a_src(a_src), .req_a_dst(a_dst),
    .req_a_imm_sel(a_imm_sel), .req_a_imm(a_imm),
    .req_b_valid(b_valid), .req_b_src(b_src), .req_b_dst(b_dst),
    .req_b_imm_sel(b_imm_sel), .req_b_imm(b_imm),
    .done_a(done_a), .done_b(done_b), .reg_addr(reg_addr),
    .reg_in_en(reg_in_en), .reg_out_en(reg_out_en),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
  );

  typedef struct {
    logic          is_b;
    logic [1:0]    src;
    logic [1:0]    dst;
    logic          imm_sel;
    logic [DW-1:0] imm;
    logic [DW-1:0] bus;
    logic          move;
    logic [DW-1:0] wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic b, input logic i, input logic o,
                            input logic da, input logic db, input logic [AW-1:0] a,
                            input logic [DW-1:0] w);
    chk({tag, " busy"}, 32'(busy), 32'(b));
    chk({tag, " in_en"}, 32'(reg_in_en), 32'(i));
    chk({tag, " out_en"}, 32'(reg_out_en), 32'(o));
    chk({tag, " done_a"}, 32'(done_a), 32'(da));
    chk({tag, " done_b"}, 32'(done_b), 32'(db));
    chk({tag, " addr"}, 32'(reg_addr), 32'(a));
    chk({tag, " wdata"}, 32'(reg_wdata), 32'(w));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    a_valid = 0; a_src = 0; a_dst = 0; a_imm_sel = 0; a_imm = 0;
    b_valid = 0; b_src = 0; b_dst = 0; b_imm_sel = 0; b_imm = 0;
  endtask

  task automatic drive_req(input logic is_b, input logic [1:0] s, input logic [1:0] d,
                           input logic isel, input logic [DW-1:0] im);
    if (is_b) begin
      b_valid = 1; b_src = s; b_dst = d; b_imm_sel = isel; b_imm = im;
    end else begin
      a_valid = 1; a_src = s; a_dst = d; a_imm_sel = isel; a_imm = im;
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 2'd1, 2'd3, 1'b0, 16'h0000, 16'h00A5, 1'b1, 16'h00A5};
    vecs[1] = '{1'b1, 2'd2, 2'd0, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 16'h5A5A};
    vecs[2] = '{1'b0, 2'd2, 2'd2, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF};
`ifdef REG_SEQ_IMMEDIATE_EN
    vecs[3] = '{1'b1, 2'd1, 2'd2, 1'b1, 16'h1234, 16'h0F0F, 1'b0, 16'h1234};
    vecs[4] = '{1'b0, 2'd3, 2'd1, 1'b1, 16'hBEEF, 16'h0001, 1'b0, 16'hBEEF};
`else
    vecs[3] = '{1'b1, 2'd1, 2'd2, 1'b1, 16'h1234, 16'h0F0F, 1'b1, 16'h0F0F};
    vecs[4] = '{1'b0, 2'd3, 2'd1, 1'b1, 16'hBEEF, 16'h0001, 1'b1, 16'h0001};
`endif

    clear_inputs();
    bus_val = 16'h1111;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // A and B together straight out of reset; A is kept high through its done.
    drive_req(0, 2'd1, 2'd3, 0, 0);
    drive_req(1, 2'd2, 2'd0, 0, 0);
    expect_out("both c0", 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("both c1 READ A", 1, 0, 1, 0, 0, 1, 0);
    step(); expect_out("both c2 WRITE A", 1, 1, 0, 0, 0, 3, 16'h1111);
    step(); expect_out("both c3 ACK A", 1, 0, 0, 1, 0, 0, 0);
    step(); expect_out("both c4 IDLE", 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("both c5 READ B", 1, 0, 1, 0, 0, 2, 0);
    clear_inputs();
    step(); expect_out("both c6 WRITE B", 1, 1, 0, 0, 0, 0, 16'h1111);
    step(); expect_out("both c7 ACK B", 1, 0, 0, 0, 1, 0, 0);
    step(); expect_out("both c8 IDLE", 0, 0, 0, 0, 0, 0, 0);

    // Valid held after done is a fresh request.
    bus_val = 16'h2222;
    drive_req(0, 2'd3, 2'd1, 0, 0);
    repeat (3) step();
    expect_out("hold c3 ACK", 1, 0, 0, 1, 0, 0, 0);
    step(); expect_out("hold c4 IDLE", 0, 0, 0, 0, 0, 0, 0);
    step(); expect_out("hold c5 READ", 1, 0, 1, 0, 0, 3, 0);
    clear_inputs();
    repeat (3) step();
    expect_out("hold c8 IDLE", 0, 0, 0, 0, 0, 0, 0);

    // Single requests; valid drops and fields change right after grant.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      bus_val = v.bus;
      drive_req(v.is_b, v.src, v.dst, v.imm_sel, v.imm);
      expect_out($sformatf("v%0d IDLE", i), 0, 0, 0, 0, 0, 0, 0);
      step();
      clear_inputs();
      if (v.is_b) begin
        b_src = ~v.src; b_dst = ~v.dst; b_imm = ~v.imm; b_imm_sel = ~v.imm_sel;
      end else begin
        a_src = ~v.src; a_dst = ~v.dst; a_imm = ~v.imm; a_imm_sel = ~v.imm_sel;
      end
      if (v.move) begin
        expect_out($sformatf("v%0d READ", i), 1, 0, 1, 0, 0, AW'(v.src), 0);
        step();
      end
      expect_out($sformatf("v%0d WRITE", i), 1, 1, 0, 0, 0, AW'(v.dst), v.wdata);
      step();
      expect_out($sformatf("v%0d ACK", i), 1, 0, 0, !v.is_b, v.is_b, 0, 0);
      step();
      clear_inputs();
    end
    expect_out("table end IDLE", 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted during WRITE aborts with no done pulse.
    bus_val = 16'h3333;
    drive_req(0, 2'd0, 2'd1, 0, 0);
    step();
    clear_inputs();
    step(); expect_out("rst WRITE", 1, 1, 0, 0, 0, 1, 16'h3333);
    rst_n = 1'b0;
    #1;
    expect_out("rst async", 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out($sformatf("rst after %0d", k), 0, 0, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_bus_sequencer.md
REG_BUS_SEQUENCER -- requirements
Module: reg_bus_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bus and register data width.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning register address width driven to the register file.
REQ-003 SHALL have port seq_clock, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port seq_reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports req_a_valid/req_b_valid, input, 1 each, meaning requester A/B asks for a transfer.
REQ-006 SHALL have ports req_a_src/req_b_src, input, 2 each, meaning source register index.
REQ-007 SHALL have ports req_a_dst/req_b_dst, input, 2 each, meaning destination register index.
REQ-008 SHALL have ports req_a_imm_sel/req_b_imm_sel, input, 1 each, meaning load-immediate request instead of a move.
REQ-009 SHALL have ports req_a_imm/req_b_imm, input, DATA_W each, meaning the immediate value.
REQ-010 SHALL have ports done_a/done_b, output, 1 each, meaning a one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port reg_addr, output, ADDR_W, meaning register file address, zero-extended from the 2-bit index.
REQ-012 SHALL have ports reg_in_en/reg_out_en, output, 1 each, meaning register file write enable and bus drive enable.
REQ-013 SHALL have port reg_wdata, output, DATA_W, meaning data written into the register file.
REQ-014 SHALL have port reg_rdata, input, DATA_W, meaning the shared bus value driven by the register file.
REQ-015 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, ACK.
REQ-017 SHALL in IDLE, on any valid, grant one requester, latch its src, dst, imm_sel, imm, and go to READ (move) or WRITE (immediate).
REQ-018 SHALL arbitrate round-robin with a 1-bit priority pointer: on simultaneous valid, the pointed requester wins; after every grant the pointer points to the other requester.
REQ-019 SHALL in READ drive reg_addr=src, reg_out_en=1, reg_in_en=0, and capture reg_rdata into a temp register at the end of the cycle; next state WRITE.
REQ-020 SHALL in WRITE drive reg_addr=dst, reg_in_en=1, reg_out_en=0, reg_wdata=temp (move) or latched imm (immediate); next state ACK.
REQ-021 SHALL in ACK pulse done of the granted requester for exactly one cycle, all enables 0; next state IDLE.
REQ-022 SHALL never assert reg_in_en and reg_out_en in the same cycle.
REQ-023 SHALL give latency from the granting IDLE cycle to done: 4 cycles for a move, 3 cycles for an immediate.
REQ-024 SHALL treat request fields as sampled only at grant; valid deasserting or fields changing mid-operation SHALL NOT abort or alter the transfer.
REQ-025 SHALL, when valid is still high in the cycle after done, treat it as a new request.
REQ-026 SHALL perform the full read and write when src equals dst.
REQ-027 SHALL drive reg_addr=0, reg_wdata=0, both enables 0 in IDLE and ACK.

Reset
REQ-028 SHALL on seq_reset_n low immediately set state IDLE, pointer to A, temp=0, and all outputs to 0.
REQ-029 SHALL on reset mid-operation abort the transfer with no write and no done pulse.

Configuration
REQ-030 SHALL compile load-immediate support only when REG_SEQ_IMMEDIATE_EN is defined; without it imm_sel and imm are ignored and every grant is a move.

Verification
REQ-031 SHALL cover: A valid, src=1, dst=3, reg_rdata=16'h00A5 in READ -> WRITE cycle addr=3, in_en=1, wdata=16'h00A5; done_a 4 cycles after grant.
REQ-032 SHALL cover: A and B valid together out of reset -> A served first, B granted in the IDLE cycle after done_a.
REQ-033 SHALL cover: with REG_SEQ_IMMEDIATE_EN, B imm_sel=1, dst=2, imm=16'h1234 -> no READ cycle, WRITE addr=2, wdata=16'h1234, done_b 3 cycles after grant.
REQ-034 SHALL cover: without REG_SEQ_IMMEDIATE_EN, same stimulus -> READ cycle with addr=src, then a move.
REQ-035 SHALL cover: seq_reset_n low during WRITE -> in_en=0 immediately, busy=0, no done pulse.
REQ-036 SHALL cover: A valid dropped after grant -> transfer completes and done_a still pulses.
